// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 user-port command path:
// command opcodes, arbiter state encoding and default address width.
package ddr3_pkg;

  localparam int ADDR_W_DEF = 26;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE_WR = 2'd1,
    ST_ISSUE_RD = 2'd2,
    ST_ACK      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR3 user command port between the write
// and read requesters, with a cap on read bursts in flight.
module ddr3_cmd_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MAX_RD_OUT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_mode,
  input  logic              wr_request,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_addr_ack,
  input  logic              rd_request,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_addr_ack,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rd_data_valid,
  input  logic              app_rd_data_end,
  output logic [3:0]        rd_outstanding,
  output logic              rd_underflow
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_RD_OUT);

  arb_state_e state_r;
  logic       last_rd_r;
  logic       wr_elig_s;
  logic       rd_elig_s;
  logic       grant_rd_s;
  logic       rd_accept_s;
  logic       burst_end_s;

  // Eligibility and round-robin choice, evaluated against registered state
  always_comb begin
    wr_elig_s   = wr_request;
    rd_elig_s   = rd_request && !wr_mode && (rd_outstanding < MAX_OUT);
    rd_accept_s = (state_r == ST_ISSUE_RD) && app_en && app_rdy;
    burst_end_s = app_rd_data_valid && app_rd_data_end;
    if (rd_elig_s && (!wr_elig_s || !last_rd_r)) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_rd_s = 1'b0;
    end
  end

  // Command FSM: grant, hold the command until accepted, then pulse the ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      last_rd_r   <= 1'b1;
      app_en      <= 1'b0;
      app_cmd     <= CMD_WR;
      app_addr    <= {ADDR_W{1'b0}};
      wr_addr_ack <= 1'b0;
      rd_addr_ack <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wr_addr_ack <= 1'b0;
          rd_addr_ack <= 1'b0;
          if (grant_rd_s) begin
            app_en   <= 1'b1;
            app_cmd  <= CMD_RD;
            app_addr <= rd_addr;
            state_r  <= ST_ISSUE_RD;
          end else if (wr_elig_s) begin
            app_en   <= 1'b1;
            app_cmd  <= CMD_WR;
            app_addr <= wr_addr;
            state_r  <= ST_ISSUE_WR;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ISSUE_WR: begin
          if (app_en && app_rdy) begin
            app_en      <= 1'b0;
            wr_addr_ack <= 1'b1;
            last_rd_r   <= 1'b0;
            state_r     <= ST_ACK;
          end else begin
            state_r     <= ST_ISSUE_WR;
          end
        end
        ST_ISSUE_RD: begin
          if (app_en && app_rdy) begin
            app_en      <= 1'b0;
            rd_addr_ack <= 1'b1;
            last_rd_r   <= 1'b1;
            state_r     <= ST_ACK;
          end else begin
            state_r     <= ST_ISSUE_RD;
          end
        end
        ST_ACK: begin
          // The requester drops its request on this edge, so nothing is sampled here
          wr_addr_ack <= 1'b0;
          rd_addr_ack <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          app_en      <= 1'b0;
          wr_addr_ack <= 1'b0;
          rd_addr_ack <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads in flight: accepted commands minus completed bursts; sticky underflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_outstanding <= 4'd0;
      rd_underflow   <= 1'b0;
    end else begin
      case ({rd_accept_s, burst_end_s})
        2'b10: rd_outstanding <= rd_outstanding + 4'd1;
        2'b01: begin
          if (rd_outstanding == 4'd0) begin
            rd_underflow <= 1'b1;
          end else begin
            rd_outstanding <= rd_outstanding - 4'd1;
          end
        end
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Self-checking bench for ddr3_cmd_arbiter: table-driven single commands
// plus hand-written sequences for arbitration, stalls, limits and reset.
module tb_ddr3_cmd_arbiter;
  import ddr3_pkg::*;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_mode, wr_request, wr_addr_ack;
  logic          rd_request, rd_addr_ack;
  logic [AW-1:0] wr_addr, rd_addr, app_addr;
  logic          app_rdy, app_en;
  logic [2:0]    app_cmd;
  logic          app_rd_data_valid, app_rd_data_end;
  logic [3:0]    rd_outstanding;
  logic          rd_underflow;

  ddr3_cmd_arbiter #(.ADDR_W(AW), .MAX_RD_OUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_mode(wr_mode),
    .wr_request(wr_request), .wr_addr(wr_addr), .wr_addr_ack(wr_addr_ack),
    .rd_request(rd_request), .rd_addr(rd_addr), .rd_addr_ack(rd_addr_ack),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic          wr_req;
    logic [AW-1:0] wr_a;
    logic          rd_req;
    logic [AW-1:0] rd_a;
    logic          wm;
    logic [2:0]    exp_cmd;
    logic [AW-1:0] exp_addr;
    int            lat;
  } vec_t;

  exp_t sb_q[$];
  int   rise_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_en = 1'b0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted command must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (app_en && app_rdy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_cmd", 32'd1, 32'd0);
        end else begin
          chk("sb_cmd", 32'(app_cmd), 32'(sb_q[0].cmd));
          chk("sb_addr", 32'(app_addr), 32'(sb_q[0].addr));
          sb_q.delete(0);
        end
      end
      if (app_en && !prev_en) rise_cyc.push_back(cyc);
      if (wr_addr_ack && rd_addr_ack) chk("both_ack", 32'd1, 32'd0);
    end
    prev_en <= app_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    wr_request = 1'b0; rd_request = 1'b0; wr_mode = 1'b0; app_rdy = 1'b1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    #20;
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic pulse_end();
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
  endtask

  // One command: drive, expect, wait for the ack, then drop the requests
  task automatic issue(input vec_t v, input string name);
    int n = 0;
    int en_n = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    wr_mode = v.wm; wr_request = v.wr_req; wr_addr = v.wr_a;
    rd_request = v.rd_req; rd_addr = v.rd_a;
    sb_q.push_back(exp_t'{v.exp_cmd, v.exp_addr});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (app_en && en_n == 0) en_n = n;
      if (wr_addr_ack || rd_addr_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_ack"}, {30'd0, wr_addr_ack, rd_addr_ack},
          (v.exp_cmd == CMD_RD) ? 32'd1 : 32'd2);
      if (v.lat != 0) begin
        chk({name, "_en_latency"}, 32'(en_n), 32'd2);
        chk({name, "_ack_latency"}, 32'(n), 32'd3);
      end
    end
    @(posedge clk); #1;
    wr_request = 1'b0; rd_request = 1'b0; wr_mode = 1'b0;
  endtask

  task automatic rd_only(input logic [AW-1:0] a, input string name);
    vec_t v;
    v = '{1'b0, 26'h0, 1'b1, a, 1'b0, CMD_RD, a, 0};
    issue(v, name);
  endtask

  // Bounded wait for app_en at a negedge; returns the number of negedges taken
  task automatic wait_en(input string name, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (app_en) break;
    end
    if (!app_en) chk({name, "_en_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int   n;
    bit   seen;
    bit   ok;
    logic [3:0] ack_seq;
    int   acks;

    tbl[0] = '{1'b0, 26'h0,       1'b1, 26'h00000A8, 1'b0, CMD_RD, 26'h00000A8, 1};
    tbl[1] = '{1'b1, 26'h0001234, 1'b0, 26'h0,       1'b0, CMD_WR, 26'h0001234, 1};
    tbl[2] = '{1'b1, 26'h0000100, 1'b1, 26'h0000200, 1'b0, CMD_RD, 26'h0000200, 1};
    tbl[3] = '{1'b1, 26'h0000300, 1'b1, 26'h0000400, 1'b0, CMD_WR, 26'h0000300, 0};
    tbl[4] = '{1'b1, 26'h0000500, 1'b1, 26'h0000600, 1'b1, CMD_WR, 26'h0000500, 0};
    tbl[5] = '{1'b1, 26'h3FFFFFF, 1'b0, 26'h0,       1'b0, CMD_WR, 26'h3FFFFFF, 0};
    tbl[6] = '{1'b0, 26'h0,       1'b1, 26'h0000000, 1'b0, CMD_RD, 26'h0000000, 0};

    wr_addr = '0; rd_addr = '0;
    do_reset();
    @(negedge clk);
    chk("rst_app_en", 32'(app_en), 32'd0);
    chk("rst_app_cmd", 32'(app_cmd), 32'd0);
    chk("rst_app_addr", 32'(app_addr), 32'd0);
    chk("rst_acks", {30'd0, wr_addr_ack, rd_addr_ack}, 32'd0);
    chk("rst_outstanding", 32'(rd_outstanding), 32'd0);
    chk("rst_underflow", 32'(rd_underflow), 32'd0);

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("vec0_outstanding", 32'(rd_outstanding), 32'd1);
        pulse_end();
        chk("vec0_returned", 32'(rd_outstanding), 32'd0);
      end
    end
    chk("table_outstanding", 32'(rd_outstanding), 32'd2);

    // Both requesters held: W,R,W,R from reset, three cycles apart
    do_reset();
    rise_cyc.delete();
    @(posedge clk); #1;
    wr_request = 1'b1; wr_addr = 26'h00AAAA0;
    rd_request = 1'b1; rd_addr = 26'h00BBBB0;
    sb_q.push_back(exp_t'{CMD_WR, 26'h00AAAA0});
    sb_q.push_back(exp_t'{CMD_RD, 26'h00BBBB0});
    sb_q.push_back(exp_t'{CMD_WR, 26'h00AAAA0});
    sb_q.push_back(exp_t'{CMD_RD, 26'h00BBBB0});
    ack_seq = 4'd0; acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (wr_addr_ack || rd_addr_ack) begin
        ack_seq = {ack_seq[2:0], rd_addr_ack};
        acks++;
      end
    end
    @(posedge clk); #1;
    wr_request = 1'b0; rd_request = 1'b0;
    chk("rr_ack_count", 32'(acks), 32'd4);
    chk("rr_order", 32'(ack_seq), 32'h5);
    if (rise_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("rr_spacing%0d", i), 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd3);
    end else begin
      chk("rr_rise_count", 32'(rise_cyc.size()), 32'd4);
    end
    chk("rr_outstanding", 32'(rd_outstanding), 32'd2);

    // wr_mode blocks reads; release issues the read on the next edge
    @(posedge clk); #1;
    wr_mode = 1'b1; rd_request = 1'b1; rd_addr = 26'h000CCC0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (app_en) seen = 1'b1;
    end
    chk("wm_block", 32'(seen), 32'd0);
    @(posedge clk); #1;
    wr_mode = 1'b0;
    sb_q.push_back(exp_t'{CMD_RD, 26'h000CCC0});
    wait_en("wm_release", n);
    chk("wm_release_latency", 32'(n), 32'd2);
    @(negedge clk);
    chk("wm_release_ack", 32'(rd_addr_ack), 32'd1);
    @(posedge clk); #1;
    rd_request = 1'b0;
    repeat (3) pulse_end();
    chk("wm_outstanding", 32'(rd_outstanding), 32'd0);

    // app_rdy low for five cycles while a write is presented
    @(posedge clk); #1;
    app_rdy = 1'b0; wr_request = 1'b1; wr_addr = 26'h1555555;
    sb_q.push_back(exp_t'{CMD_WR, 26'h1555555});
    wait_en("stall", n);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!app_en || app_addr !== 26'h1555555 || app_cmd !== CMD_WR || wr_addr_ack)
        ok = 1'b0;
    end
    chk("stall_hold", 32'(ok), 32'd1);
    @(posedge clk); #1;
    app_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_ack", 32'(wr_addr_ack), 32'd1);
    @(posedge clk); #1;
    wr_request = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (app_en || wr_addr_ack) seen = 1'b1;
    end
    chk("stall_no_dup", 32'(seen), 32'd0);

    // Read limit: eight in flight stalls the ninth until a burst returns
    do_reset();
    for (int i = 0; i < 8; i++) rd_only(26'(i * 8), $sformatf("lim%0d", i));
    chk("lim_outstanding8", 32'(rd_outstanding), 32'd8);
    @(posedge clk); #1;
    rd_request = 1'b1; rd_addr = 26'h0000480;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (app_en) seen = 1'b1;
    end
    chk("lim_stall9", 32'(seen), 32'd0);
    sb_q.push_back(exp_t'{CMD_RD, 26'h0000480});
    pulse_end();
    wait_en("lim9", n);
    @(negedge clk);
    chk("lim9_ack", 32'(rd_addr_ack), 32'd1);
    @(posedge clk); #1;
    rd_request = 1'b0;
    chk("lim9_outstanding", 32'(rd_outstanding), 32'd8);
    pulse_end();
    chk("lim_outstanding7", 32'(rd_outstanding), 32'd7);
    @(posedge clk); #1;
    rd_request = 1'b1; rd_addr = 26'h00004C0;
    sb_q.push_back(exp_t'{CMD_RD, 26'h00004C0});
    wait_en("simul", n);
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    @(negedge clk);
    chk("simul_ack", 32'(rd_addr_ack), 32'd1);
    @(posedge clk); #1;
    rd_request = 1'b0;
    chk("simul_outstanding", 32'(rd_outstanding), 32'd7);

    // Reset while a command is presented, then underflow stickiness
    @(posedge clk); #1;
    app_rdy = 1'b0; wr_request = 1'b1; wr_addr = 26'h000002A;
    wait_en("midrst", n);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_app_en", 32'(app_en), 32'd0);
    chk("midrst_ack", {30'd0, wr_addr_ack, rd_addr_ack}, 32'd0);
    chk("midrst_outstanding", 32'(rd_outstanding), 32'd0);
    sb_q.delete();
    wr_request = 1'b0; app_rdy = 1'b1;
    #10;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (app_en || wr_addr_ack || rd_addr_ack) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);
    pulse_end();
    chk("uf_set", 32'(rd_underflow), 32'd1);
    chk("uf_count", 32'(rd_outstanding), 32'd0);
    repeat (5) @(negedge clk);
    chk("uf_sticky", 32'(rd_underflow), 32'd1);
    do_reset();
    #1;
    chk("uf_cleared", 32'(rd_underflow), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
